// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;
  localparam int DEF_CNT_W  = $clog2(DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bcd_seq_converter_add_3.sv
// Double-dabble digit correction cell: adds 3 to a BCD digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module add_3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bcd_seq_converter.sv
// Signed binary to packed BCD converter, one shift-and-add-3 step per clock.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int ACC_W = 4 * DIGITS;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               neg_q, neg_d;
  logic               sign_q, sign_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;

  logic [ACC_W-1:0]       acc_corr;
  logic [ACC_W+WIDTH-1:0] shift_vec;
  logic [ACC_W-1:0]       acc_shift;
  logic [WIDTH-1:0]       mag_shift;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      add_3 u_add_3 (
        .digit_i (acc_q[4*g +: 4]),
        .digit_o (acc_corr[4*g +: 4])
      );
    end
  endgenerate

  // Corrected accumulator and magnitude shift as one vector; mag MSB feeds acc LSB.
  assign shift_vec = {acc_corr, mag_q} << 1;
  assign acc_shift = shift_vec[ACC_W+WIDTH-1:WIDTH];
  assign mag_shift = shift_vec[WIDTH-1:0];

  // Next-state and datapath next values; everything holds unless the state acts on it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          neg_d   = bin_in[WIDTH-1];
          // Most negative input wraps to 2^(WIDTH-1), correct as unsigned.
          mag_d   = bin_in[WIDTH-1] ? (~bin_in + WIDTH'(1)) : bin_in;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        mag_d = mag_shift;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Result is loaded on the final shift edge so it is visible during DONE.
          bcd_d   = acc_shift;
          sign_d  = neg_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      mag_q  <= '0;
      neg_q  <= 1'b0;
      sign_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      mag_q  <= mag_d;
      neg_q  <= neg_d;
      sign_q <= sign_d;
      bcd_q  <= bcd_d;
    end
  end

  assign busy    = (state_q == SHIFT) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign sign    = sign_q;
  assign bcd_out = bcd_q;

endmodule

// File: doc/bcd_seq_converter.md
# bcd_seq_converter

Sequential signed-binary-to-BCD converter for the multiplier result path. It takes a WIDTH-bit two's-complement product and produces a sign flag plus DIGITS packed BCD digits. It uses the iterative shift-and-add-3 (double-dabble) method, one bit per clock. It owns the FSM and counter that sequence a bank of add_3 digit-correction cells, and sits between the multiplier's result register and the display/readout logic.

## Interface
Parameters:
- WIDTH, 16: binary input width in bits, two's complement.
- DIGITS, 5: number of BCD output digits. Must satisfy 10^DIGITS > 2^(WIDTH-1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of bin_in. Sampled only in IDLE.
- bin_in  input  WIDTH  signed operand, captured on the accepting edge.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse when sign and bcd_out become valid.
- sign  output  1  1 when the captured operand was negative.
- bcd_out  output  4*DIGITS  packed BCD magnitude, most significant digit in the top nibble.

## Operation
- States:
  - IDLE (reset state).
  - SHIFT: WIDTH iterations.
  - DONE: one cycle.
- IDLE:
  - If start=1, capture sign = bin_in[WIDTH-1] and mag = |bin_in| as WIDTH-bit unsigned.
  - Clear the internal BCD accumulator to 0, load cnt = WIDTH, go to SHIFT.
  - If start=0, stay in IDLE.
- Magnitude: mag = sign ? (~bin_in + 1) : bin_in, truncated to WIDTH bits. The most negative input (e.g. 0x8000) yields mag = 2^(WIDTH-1), which is correct as unsigned.
- SHIFT, per cycle:
  - Each 4-bit accumulator digit passes through add_3: digit ≥5 → +3, else unchanged.
  - The corrected accumulator and mag shift left by 1 as one {acc, mag} vector; mag's MSB enters acc's LSB.
  - cnt decrements. When cnt reaches 1 on this edge (the last shift), go to DONE.
- DONE:
  - Register the accumulator into bcd_out and the captured sign into sign.
  - done=1 for exactly this cycle, then IDLE.
- Outputs sign and bcd_out hold their last result until the next DONE. They do not change during SHIFT.
- start while busy=1, including the DONE cycle, is ignored. There is no queuing.
- Zero input gives sign=0. Negative zero cannot occur.
- Reset (rst_n=0) at any time:
  - state=IDLE, cnt=0, accumulator=0, mag=0.
  - sign=0, bcd_out=0, busy=0, done=0.
  - An in-flight conversion is discarded with no done pulse.

## Timing
- Start accepted at edge E0. SHIFT occupies edges E1..E_WIDTH. DONE is entered at E_WIDTH, with done, sign and bcd_out valid in the cycle following that edge.
- For WIDTH=16: done is high in the 17th cycle after the accepting edge, with 16 shift edges.
- The earliest next accept is the edge ending the DONE cycle plus one, i.e. start sampled in the IDLE cycle after done. Minimum throughput is one conversion per WIDTH+2 cycles.
- busy rises in the cycle after the accepting edge and falls in the cycle after done.
- The add_3 path is purely combinational within one cycle. No multicycle paths.

## Structure
- Shared package/header bcd_pkg:
  - State localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Default WIDTH and DIGITS.
  - Counter width $clog2(WIDTH+1).
- Sub-module: the existing add_3 cell, instantiated DIGITS times in a generate loop over the accumulator nibbles. No new sub-module is needed.
- Single FSM process plus a datapath register process. busy is decoded from state.

## Test plan
- Reset, then start with bin_in=16'd0 → done at cycle 17, sign=0, bcd_out=20'h00000.
- bin_in=16'd16384 (−128×−128) → sign=0, bcd_out=20'h16384. bin_in=16'd9999 → 20'h09999.
- bin_in=16'hC080 (−16256) → sign=1, bcd_out=20'h16256. bin_in=16'hFFFF (−1) → sign=1, 20'h00001.
- bin_in=16'h8000 → sign=1, 20'h32768. bin_in=16'h7FFF → sign=0, 20'h32767.
- Start 16'd123 at E0, then start with bin_in=16'd456 at E5 and again during DONE → only 20'h00123 reported, one done pulse. A start in the following IDLE cycle converts 456 correctly.
- rst_n low for 1 cycle mid-SHIFT (E8) → all outputs 0 immediately, no done. A new start of 16'd77 yields 20'h00077 17 cycles later.
